// File: rtl/click_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// click_arbiter_pkg
//   Shared definitions for the click arbiter slice:
//     - default sizing for requesters, pending counters and id width
//     - FSM state encoding (ST_IDLE / ST_OFFER)
//     - drop-counter width and a lost-click population count helper, present
//       only when CLICK_ARB_DROP_CNT_EN is defined
// -----------------------------------------------------------------------------
package click_arbiter_pkg;

    localparam int N_REQ_DEF  = 4;
    localparam int PEND_W_DEF = 3;
    localparam int ID_W_DEF   = 2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OFFER = 1'b1
    } state_t;

`ifdef CLICK_ARB_DROP_CNT_EN
    localparam int DROP_W = 8;

    // Number of set bits in an 8-bit vector (N_REQ never exceeds 8).
    function automatic logic [3:0] count_ones8(input logic [7:0] v);
        logic [3:0] c;
        c = '0;
        for (int i = 0; i < 8; i++) begin
            c = c + {3'b000, v[i]};
        end
        return c;
    endfunction
`endif

endpackage

// File: rtl/click_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// click_arbiter_rr_pick
//   Combinational round-robin picker. Returns the first requester with req set,
//   searching ptr, ptr+1, ... wrapping modulo N_REQ.
// Ports:
//   req     in   N_REQ  request vector (pending counter nonzero)
//   ptr     in   ID_W   index searched first (always < N_REQ)
//   winner  out  ID_W   selected requester index (0 when nothing found)
//   found   out  1      at least one request was set
// -----------------------------------------------------------------------------
module click_arbiter_rr_pick #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [ID_W-1:0]  winner,
    output logic             found
);

    function automatic int wrap_idx(input int base, input int off);
        return (base + off) % N_REQ;
    endfunction

    // Walk offsets from farthest to nearest so the last hit (smallest offset
    // from ptr) is the one that sticks.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req[wrap_idx(int'(ptr), k)]) begin
                winner = ID_W'(wrap_idx(int'(ptr), k));
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/click_arbiter.sv
// -----------------------------------------------------------------------------
// click_arbiter
//   Merges N_REQ confirmed-click pulses onto one score-update port. Each
//   requester owns a saturating pending counter; a two-state FSM offers one
//   buffered click at a time with a valid/ready handshake, choosing round-robin.
// Optional feature macro: CLICK_ARB_DROP_CNT_EN adds the drop_cnt port and an
//   8-bit saturating counter of all lost clicks.
// Ports:
//   clk        in   1      clock, all logic on posedge
//   rst        in   1      synchronous active-high reset
//   click      in   N_REQ  one click per cycle per high bit
//   out_valid  out  1      a click is offered
//   out_id     out  ID_W   requester index of the offered click
//   out_ready  in   1      accumulator accepts (transfer = out_valid & out_ready)
//   pend_any   out  1      some pending counter nonzero (registered)
//   ovf        out  N_REQ  sticky per-requester lost-click flag
//   clr_ovf    in   1      clears ovf; a new loss in the same cycle wins
//   drop_cnt   out  8      [CLICK_ARB_DROP_CNT_EN] saturating lost-click total
// -----------------------------------------------------------------------------
module click_arbiter
    import click_arbiter_pkg::*;
#(
    parameter int N_REQ  = N_REQ_DEF,
    parameter int PEND_W = PEND_W_DEF,
    parameter int ID_W   = ID_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_REQ-1:0]  click,
    output logic              out_valid,
    output logic [ID_W-1:0]   out_id,
    input  logic              out_ready,
    output logic              pend_any,
    output logic [N_REQ-1:0]  ovf,
    input  logic              clr_ovf
`ifdef CLICK_ARB_DROP_CNT_EN
    ,
    output logic [DROP_W-1:0] drop_cnt
`endif
);

    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    state_t             state_q, state_d;
    logic               out_valid_q, out_valid_d;
    logic [ID_W-1:0]    out_id_q, out_id_d;
    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic               pend_any_q, pend_any_d;
    logic [N_REQ-1:0]   ovf_q, ovf_d;

    logic               transfer;
    logic [N_REQ-1:0]   pend_nz;       // registered counters nonzero
    logic [N_REQ-1:0]   pend_nz_next;  // counters nonzero after this edge
    logic [N_REQ-1:0]   lost;          // click dropped at saturation this cycle
    logic [ID_W-1:0]    pick_id;
    logic               pick_found;
    logic [ID_W-1:0]    id_inc;

    assign transfer = out_valid_q & out_ready;

    // ---------------------------------------------------------------- counters
    for (genvar gi = 0; gi < N_REQ; gi++) begin : gen_pend
        logic [PEND_W-1:0] pend_q, pend_d;
        logic              dec;
        logic              lost_bit;

        assign dec = transfer && (out_id_q == ID_W'(gi));

        // Increment and decrement in the same cycle cancel, so a saturated
        // counter only loses a click when nothing is draining it.
        always_comb begin
            pend_d   = pend_q;
            lost_bit = 1'b0;
            if (click[gi] && !dec) begin
                if (pend_q == PEND_MAX) begin
                    lost_bit = 1'b1;
                end else begin
                    pend_d = pend_q + PEND_W'(1);
                end
            end else if (!click[gi] && dec) begin
                pend_d = pend_q - PEND_W'(1);
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                pend_q <= '0;
            end else begin
                pend_q <= pend_d;
            end
        end

        assign pend_nz[gi]      = |pend_q;
        assign pend_nz_next[gi] = |pend_d;
        assign lost[gi]         = lost_bit;
    end

    // ---------------------------------------------------------------- picker
    // Arbitration looks at the registered counters; a winner is therefore
    // guaranteed to hold at least one click when its offer is accepted.
    click_arbiter_rr_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_pick (
        .req    (pend_nz),
        .ptr    (rr_ptr_q),
        .winner (pick_id),
        .found  (pick_found)
    );

    assign id_inc = (out_id_q == ID_W'(N_REQ - 1)) ? '0 : out_id_q + ID_W'(1);

    // ---------------------------------------------------------------- FSM
    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        out_id_d    = out_id_q;
        rr_ptr_d    = rr_ptr_q;
        case (state_q)
            ST_IDLE: begin
                out_valid_d = 1'b0;
                if (pick_found) begin
                    out_id_d    = pick_id;
                    out_valid_d = 1'b1;
                    state_d     = ST_OFFER;
                end
            end
            ST_OFFER: begin
                // Offer is held unchanged until accepted.
                out_valid_d = 1'b1;
                if (transfer) begin
                    out_valid_d = 1'b0;
                    rr_ptr_d    = id_inc;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    assign pend_any_d = |pend_nz_next;
    assign ovf_d      = (ovf_q & ~{N_REQ{clr_ovf}}) | lost;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            out_id_q    <= '0;
            rr_ptr_q    <= '0;
            pend_any_q  <= 1'b0;
            ovf_q       <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_id_q    <= out_id_d;
            rr_ptr_q    <= rr_ptr_d;
            pend_any_q  <= pend_any_d;
            ovf_q       <= ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_id    = out_id_q;
    assign pend_any  = pend_any_q;
    assign ovf       = ovf_q;

`ifdef CLICK_ARB_DROP_CNT_EN
    // ---------------------------------------------------------------- drops
    logic [DROP_W-1:0] drop_q, drop_d;
    logic [DROP_W:0]   drop_sum;
    logic [7:0]        lost8;

    assign lost8    = 8'(lost);
    // One extra bit catches the carry; several losses in one cycle add at once.
    assign drop_sum = {1'b0, drop_q} + (DROP_W + 1)'(count_ones8(lost8));
    assign drop_d   = drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_q <= '0;
        end else begin
            drop_q <= drop_d;
        end
    end

    assign drop_cnt = drop_q;
`endif

endmodule

// File: tb/tb_click_arbiter.sv
// -----------------------------------------------------------------------------
// tb_click_arbiter
//   Directed bench for click_arbiter (N_REQ=4, PEND_W=3, ID_W=2). Expected
//   grant ids are queued as stimulus is issued; a negedge monitor pops and
//   compares on every accepted offer. Direct checks cover reset, latency,
//   stall, saturation/ovf, same-cycle increment/decrement and reset mid-offer.
// -----------------------------------------------------------------------------
module tb_click_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] click;
    logic       out_valid;
    logic [1:0] out_id;
    logic       out_ready;
    logic       pend_any;
    logic [3:0] ovf;
    logic       clr_ovf;
`ifdef CLICK_ARB_DROP_CNT_EN
    logic [7:0] drop_cnt;
`endif

    int          errors = 0;
    int          checks = 0;
    int          exp_q[$];
    logic [31:0] exp_id;

    always #5 clk = ~clk;

    click_arbiter #(
        .N_REQ  (4),
        .PEND_W (3),
        .ID_W   (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .click     (click),
        .out_valid (out_valid),
        .out_id    (out_id),
        .out_ready (out_ready),
        .pend_any  (pend_any),
        .ovf       (ovf),
        .clr_ovf   (clr_ovf)
`ifdef CLICK_ARB_DROP_CNT_EN
        ,
        .drop_cnt  (drop_cnt)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: an offer seen with ready high at negedge is
    // transferred at the next posedge.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_xfer: got id %0d, expected no transfer", out_id);
            end else begin
                exp_id = 32'(exp_q.pop_front());
                $display("xfer id=%0d expected=%0d", out_id, exp_id);
                check("xfer_id", 32'(out_id), exp_id);
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        click     = 4'b1111;   // discarded during reset
        out_ready = 1'b0;
        clr_ovf   = 1'b0;
        step();
        step();
        click = 4'b0000;
        step();
        rst = 1'b0;

        // ---------------- reset state
        @(negedge clk);
        check("rst_valid", 32'(out_valid), 0);
        check("rst_id", 32'(out_id), 0);
        check("rst_pend_any", 32'(pend_any), 0);
        check("rst_ovf", 32'(ovf), 0);
`ifdef CLICK_ARB_DROP_CNT_EN
        check("rst_drop", 32'(drop_cnt), 0);
`endif
        repeat (3) step();
        @(negedge clk);
        check("rst_discard_valid", 32'(out_valid), 0);
        check("rst_discard_pend", 32'(pend_any), 0);

        // ---------------- single click on requester 2
        out_ready = 1'b1;
        click     = 4'b0100;
        exp_q.push_back(2);
        step();
        click = 4'b0000;
        @(negedge clk);
        check("single_pend_any_e0", 32'(pend_any), 1);
        check("single_valid_e0", 32'(out_valid), 0);
        step();
        @(negedge clk);
        check("single_valid_e1", 32'(out_valid), 1);
        check("single_id_e1", 32'(out_id), 2);
        step();
        @(negedge clk);
        check("single_valid_e2", 32'(out_valid), 0);
        check("single_pend_any_e2", 32'(pend_any), 0);

        // ---------------- round-robin, all four at once from rr_ptr=0
        do_reset();
        click = 4'b1111;
        exp_q.push_back(0);
        exp_q.push_back(1);
        exp_q.push_back(2);
        exp_q.push_back(3);
        step();
        click = 4'b0000;
        for (int k = 1; k <= 8; k++) begin
            step();
            @(negedge clk);
            check("rr_valid_pattern", 32'(out_valid), (k % 2 == 1) ? 32'd1 : 32'd0);
        end
        check("rr_pend_any_end", 32'(pend_any), 0);

        // ---------------- stall: offer held while out_ready=0
        out_ready = 1'b0;
        click     = 4'b0010;
        exp_q.push_back(1);
        step();
        click = 4'b0000;
        step();
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("stall_valid", 32'(out_valid), 1);
            check("stall_id", 32'(out_id), 1);
            step();
        end
        out_ready = 1'b1;
        step();
        @(negedge clk);
        check("stall_released_valid", 32'(out_valid), 0);

        // ---------------- saturation on requester 0 (rr_ptr now 2)
        out_ready = 1'b0;
        click     = 4'b0001;
        repeat (9) step();
        click = 4'b0000;
        @(negedge clk);
        check("sat_ovf", 32'(ovf), 1);
        check("sat_pend_any", 32'(pend_any), 1);
        check("sat_valid", 32'(out_valid), 1);
        check("sat_id", 32'(out_id), 0);
`ifdef CLICK_ARB_DROP_CNT_EN
        check("sat_drop", 32'(drop_cnt), 2);
`endif
        // new loss and clear in the same cycle: set wins
        click   = 4'b0001;
        clr_ovf = 1'b1;
        step();
        click   = 4'b0000;
        clr_ovf = 1'b0;
        @(negedge clk);
        check("ovf_set_wins", 32'(ovf), 1);
`ifdef CLICK_ARB_DROP_CNT_EN
        check("sat_drop_3", 32'(drop_cnt), 3);
`endif
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        @(negedge clk);
        check("ovf_cleared", 32'(ovf), 0);
        // drain the seven buffered clicks
        out_ready = 1'b1;
        for (int k = 0; k < 7; k++) exp_q.push_back(0);
        repeat (16) step();
        @(negedge clk);
        check("drain_pend_any", 32'(pend_any), 0);
        check("drain_valid", 32'(out_valid), 0);

        // ---------------- transfer and new click on the same requester
        out_ready = 1'b0;
        click     = 4'b1000;
        exp_q.push_back(3);
        step();
        click = 4'b0000;
        step();
        @(negedge clk);
        check("simul_offer_valid", 32'(out_valid), 1);
        check("simul_offer_id", 32'(out_id), 3);
        step();
        out_ready = 1'b1;
        click     = 4'b1000;
        exp_q.push_back(3);
        step();
        click = 4'b0000;
        @(negedge clk);
        check("simul_bubble_valid", 32'(out_valid), 0);
        check("simul_pend_kept", 32'(pend_any), 1);
        step();
        @(negedge clk);
        check("simul_reoffer_valid", 32'(out_valid), 1);
        check("simul_reoffer_id", 32'(out_id), 3);
        step();
        @(negedge clk);
        check("simul_done_valid", 32'(out_valid), 0);
        check("simul_done_pend", 32'(pend_any), 0);

        // ---------------- reset while an offer is pending
        out_ready = 1'b0;
        click     = 4'b0010;
        step();
        click = 4'b0000;
        step();
        @(negedge clk);
        check("midrst_offer_valid", 32'(out_valid), 1);
        check("midrst_offer_id", 32'(out_id), 1);
        step();
        rst       = 1'b1;
        out_ready = 1'b1;
        click     = 4'b0100;
        step();
        rst   = 1'b0;
        click = 4'b0000;
        @(negedge clk);
        check("midrst_valid", 32'(out_valid), 0);
        check("midrst_id", 32'(out_id), 0);
        check("midrst_pend_any", 32'(pend_any), 0);
        check("midrst_ovf", 32'(ovf), 0);
        for (int k = 0; k < 5; k++) begin
            step();
            @(negedge clk);
            check("midrst_no_offer", 32'(out_valid), 0);
        end

        check("queue_drained", 32'(exp_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
